// File: rtl/minmax_dist_engine_if.sv
// Start/done handshake and byte-wide data-memory port of the min/max distance engine.
interface minmax_dist_engine_if #(
   parameter int unsigned AW = 8
);
   logic          start;
   logic          done;
   logic          busy;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata;
   logic [7:0]    mem_wdata;
   logic          mem_we;

   modport master (output start, mem_rdata,
                   input  done, busy, mem_addr, mem_wdata, mem_we);
   modport slave  (input  start, mem_rdata,
                   output done, busy, mem_addr, mem_wdata, mem_we);
endinterface

// File: rtl/minmax_dist_engine.sv
// Loads N_VALS signed 16-bit values, scans all unordered pairs for min/max |a-b|, writes results back.
// Optional MINMAX_LOC_EN also records and writes the (j,k) indices of the winning pairs.
module minmax_dist_engine #(
   parameter int unsigned N_VALS    = 32,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned RES_ADDR  = 66,
   parameter int unsigned AW        = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   minmax_dist_engine_if.slave   bus
);
   localparam int unsigned NB  = N_VALS * 2;
   localparam int unsigned BCW = $clog2(NB);
   localparam int unsigned IW  = $clog2(N_VALS);
`ifdef MINMAX_LOC_EN
   localparam int unsigned N_WR = 8;
`else
   localparam int unsigned N_WR = 4;
`endif
   localparam int unsigned WCW = $clog2(N_WR + 1);

   typedef enum logic [2:0] {IDLE, LOAD, SCAN, WR, DONE} state_t;

   state_t             state_q;
   logic [BCW-1:0]     byte_q;
   logic [7:0]         hi_q;
   logic [IW-1:0]      j_q, k_q;
   logic [WCW-1:0]     wr_q;
   logic [15:0]        min_q, min_d, max_q, max_d;
   logic               done_q, busy_q, we_q;
   logic [AW-1:0]      addr_q;
   logic [7:0]         wdata_q;
   logic signed [15:0] vals_q [N_VALS];
   logic signed [16:0] diff_c;
   logic [15:0]        dist_c;
   logic               min_upd_c, max_upd_c, last_pair_c;
   logic [7:0]         res_c [8];
`ifdef MINMAX_LOC_EN
   logic [IW-1:0]      min_j_q, min_k_q, max_j_q, max_k_q;
   logic [IW-1:0]      min_j_d, min_k_d, max_j_d, max_k_d;
`endif

   assign bus.done      = done_q;
   assign bus.busy      = busy_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

   // Operand cache; a value is complete when its low (odd) byte arrives.
   always_ff @(posedge clk) begin
      if (state_q == LOAD && byte_q[0])
         vals_q[byte_q[BCW-1:1]] <= {hi_q, bus.mem_rdata};
   end

   // Pair distance and next min/max; the *_d values already include the pair in flight.
   always_comb begin
      diff_c      = {vals_q[j_q][15], vals_q[j_q]} - {vals_q[k_q][15], vals_q[k_q]};
      dist_c      = diff_c[16] ? 16'(-diff_c) : diff_c[15:0];
      min_upd_c   = (state_q == SCAN) && (dist_c < min_q);
      max_upd_c   = (state_q == SCAN) && (dist_c > max_q);
      last_pair_c = (j_q == IW'(N_VALS - 2)) && (k_q == IW'(N_VALS - 1));
      min_d       = min_upd_c ? dist_c : min_q;
      max_d       = max_upd_c ? dist_c : max_q;
      for (int i = 0; i < 8; i++) res_c[i] = '0;
      res_c[0] = min_d[15:8];
      res_c[1] = min_d[7:0];
      res_c[2] = max_d[15:8];
      res_c[3] = max_d[7:0];
`ifdef MINMAX_LOC_EN
      min_j_d  = min_upd_c ? j_q : min_j_q;
      min_k_d  = min_upd_c ? k_q : min_k_q;
      max_j_d  = max_upd_c ? j_q : max_j_q;
      max_k_d  = max_upd_c ? k_q : max_k_q;
      res_c[4] = 8'(min_j_d);
      res_c[5] = 8'(min_k_d);
      res_c[6] = 8'(max_j_d);
      res_c[7] = 8'(max_k_d);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         byte_q  <= '0;
         hi_q    <= '0;
         j_q     <= '0;
         k_q     <= '0;
         wr_q    <= '0;
         min_q   <= 16'hFFFF;
         max_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef MINMAX_LOC_EN
         min_j_q <= '0;
         min_k_q <= '0;
         max_j_q <= '0;
         max_k_q <= '0;
`endif
      end else begin
         min_q <= min_d;
         max_q <= max_d;
`ifdef MINMAX_LOC_EN
         min_j_q <= min_j_d;
         min_k_q <= min_k_d;
         max_j_q <= max_j_d;
         max_k_q <= max_k_d;
`endif
         case (state_q)
            IDLE: begin
               if (!bus.start) begin
                  state_q <= LOAD;
                  busy_q  <= 1'b1;
                  addr_q  <= AW'(BASE_ADDR);
                  byte_q  <= '0;
                  min_q   <= 16'hFFFF;
                  max_q   <= '0;
`ifdef MINMAX_LOC_EN
                  min_j_q <= '0;
                  min_k_q <= '0;
                  max_j_q <= '0;
                  max_k_q <= '0;
`endif
               end
            end
            LOAD: begin
               if (!byte_q[0]) hi_q <= bus.mem_rdata;
               if (byte_q == BCW'(NB - 1)) begin
                  state_q <= SCAN;
                  j_q     <= '0;
                  k_q     <= IW'(1);
               end else begin
                  byte_q <= byte_q + BCW'(1);
                  addr_q <= addr_q + AW'(1);
               end
            end
            SCAN: begin
               if (last_pair_c) begin
                  state_q <= WR;
                  we_q    <= 1'b1;
                  addr_q  <= AW'(RES_ADDR);
                  wdata_q <= res_c[0];
                  wr_q    <= WCW'(1);
               end else if (k_q == IW'(N_VALS - 1)) begin
                  j_q <= j_q + IW'(1);
                  k_q <= j_q + IW'(2);
               end else begin
                  k_q <= k_q + IW'(1);
               end
            end
            WR: begin
               if (wr_q == WCW'(N_WR)) begin
                  state_q <= DONE;
                  we_q    <= 1'b0;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  addr_q  <= AW'(RES_ADDR) + AW'(wr_q);
                  wdata_q <= res_c[3'(wr_q)];
                  wr_q    <= wr_q + WCW'(1);
               end
            end
            DONE: begin
               if (bus.start) begin
                  state_q <= IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_minmax_dist_engine.sv
// Randomised bench for minmax_dist_engine against a pairwise brute-force reference model.
`timescale 1ns/1ps
module tb_minmax_dist_engine;
   localparam int N   = 32;
   localparam int RES = 66;
`ifdef MINMAX_LOC_EN
   localparam int N_WR = 8;
`else
   localparam int N_WR = 4;
`endif
   localparam int LAT = 560 + N_WR;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   minmax_dist_engine_if #(.AW(8)) bus ();

   minmax_dist_engine #(
      .N_VALS(32), .BASE_ADDR(0), .RES_ADDR(66), .AW(8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [7:0] init_mem [256];
   logic [7:0] res_mem  [256];
   logic       clr_res;
   int         wr_seen;
   logic       stray;

   assign bus.mem_rdata = init_mem[bus.mem_addr];

   // Result memory: captures DUT writes, flags any write outside the result window.
   always @(posedge clk) begin
      if (clr_res) begin
         for (int a = RES; a < RES + 8; a++) res_mem[a] <= 8'hA5;
         wr_seen <= 0;
         stray   <= 1'b0;
      end else if (bus.mem_we) begin
         res_mem[bus.mem_addr] <= bus.mem_wdata;
         wr_seen <= wr_seen + 1;
         if (int'(bus.mem_addr) < RES || int'(bus.mem_addr) >= RES + N_WR) stray <= 1'b1;
      end
   end

   int total = 0;
   int bad   = 0;
   int vals [N];
   int m_min, m_max, m_minj, m_mink, m_maxj, m_maxk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: brute force over all j<k in scan order, earliest strict winner kept.
   function automatic void model();
      int d;
      m_min = 65535; m_max = 0;
      m_minj = 0; m_mink = 0; m_maxj = 0; m_maxk = 0;
      for (int j = 0; j < N - 1; j++)
         for (int k = j + 1; k < N; k++) begin
            d = vals[j] - vals[k];
            if (d < 0) d = -d;
            if (d < m_min) begin m_min = d; m_minj = j; m_mink = k; end
            if (d > m_max) begin m_max = d; m_maxj = j; m_maxk = k; end
         end
   endfunction

   task automatic load_mem();
      logic [15:0] w;
      for (int i = 0; i < N; i++) begin
         w = 16'(vals[i]);
         init_mem[2*i]   = w[15:8];
         init_mem[2*i+1] = w[7:0];
      end
   endtask

   task automatic do_run(input string tag, input int raise_at);
      int   lat;
      logic busy_ok;
      load_mem();
      model();
      @(negedge clk) clr_res = 1'b1;
      @(negedge clk) begin clr_res = 1'b0; bus.start = 1'b0; end
      @(posedge clk);
      lat = 0;
      busy_ok = 1'b1;
      while (lat < 3000) begin
         @(posedge clk);
         lat++;
         #1;
         if (lat == raise_at) bus.start = 1'b1;
         if (bus.done) break;
         if (!bus.busy) busy_ok = 1'b0;
      end
      check({tag, " latency"}, 32'(lat), 32'(LAT));
      check({tag, " busy_during_run"}, {31'b0, busy_ok}, 32'd1);
      check({tag, " busy_at_done"}, {31'b0, bus.busy}, 32'd0);
      check({tag, " write_count"}, 32'(wr_seen), 32'(N_WR));
      check({tag, " stray_write"}, {31'b0, stray}, 32'd0);
      check({tag, " min"}, {16'b0, res_mem[RES], res_mem[RES+1]}, 32'(m_min));
      check({tag, " max"}, {16'b0, res_mem[RES+2], res_mem[RES+3]}, 32'(m_max));
`ifdef MINMAX_LOC_EN
      check({tag, " min_loc"}, {16'b0, res_mem[RES+4], res_mem[RES+5]}, 32'(m_minj * 256 + m_mink));
      check({tag, " max_loc"}, {16'b0, res_mem[RES+6], res_mem[RES+7]}, 32'(m_maxj * 256 + m_maxk));
`endif
      if (raise_at == 0) begin
         repeat (3) @(posedge clk);
         #1;
         check({tag, " done_held"}, {31'b0, bus.done}, 32'd1);
         check({tag, " no_restart"}, 32'(wr_seen), 32'(N_WR));
      end
      @(negedge clk) bus.start = 1'b1;
      @(posedge clk);
      #1;
      check({tag, " done_fall"}, {31'b0, bus.done}, 32'd0);
   endtask

   initial begin
      for (int a = 0; a < 256; a++) init_mem[a] = 8'h00;
      rst_n     = 1'b0;
      bus.start = 1'b1;
      clr_res   = 1'b0;
      #12;
      check("reset done",  {31'b0, bus.done},   32'd0);
      check("reset busy",  {31'b0, bus.busy},   32'd0);
      check("reset we",    {31'b0, bus.mem_we}, 32'd0);
      check("reset addr",  {24'b0, bus.mem_addr},  32'd0);
      check("reset wdata", {24'b0, bus.mem_wdata}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // Arithmetic ramp: min 3, max 93.
      for (int i = 0; i < N; i++) vals[i] = i * 3;
      do_run("ramp", 0);
      check("ramp model_min", 32'(m_min), 32'd3);
      check("ramp model_max", 32'(m_max), 32'd93);
      check("ramp bytes", {res_mem[RES], res_mem[RES+1], res_mem[RES+2], res_mem[RES+3]}, 32'h0003_005D);

      // Full-range extremes: max 65535 without saturation.
      for (int i = 0; i < N; i++) vals[i] = 0;
      vals[0] = -32768;
      vals[1] = 32767;
      do_run("extreme", 0);
      check("extreme bytes", {res_mem[RES], res_mem[RES+1], res_mem[RES+2], res_mem[RES+3]}, 32'h0000_FFFF);

      // All equal: max never updates from its initial value.
      for (int i = 0; i < N; i++) vals[i] = 32'h1234;
      do_run("equal", 0);
      check("equal bytes", {res_mem[RES], res_mem[RES+1], res_mem[RES+2], res_mem[RES+3]}, 32'h0000_0000);
`ifdef MINMAX_LOC_EN
      check("equal locs", {res_mem[RES+4], res_mem[RES+5], res_mem[RES+6], res_mem[RES+7]}, 32'h0001_0000);
`endif

      // start released early: run still completes on time.
      for (int i = 0; i < N; i++) vals[i] = int'($urandom_range(0, 65535)) - 32768;
      do_run("early_release", 100);

      // Reset mid-scan: outputs drop, result bytes untouched.
      for (int i = 0; i < N; i++) vals[i] = int'($urandom_range(0, 65535)) - 32768;
      load_mem();
      @(negedge clk) clr_res = 1'b1;
      @(negedge clk) begin clr_res = 1'b0; bus.start = 1'b0; end
      @(posedge clk);
      repeat (300) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midreset done", {31'b0, bus.done},   32'd0);
      check("midreset we",   {31'b0, bus.mem_we}, 32'd0);
      check("midreset busy", {31'b0, bus.busy},   32'd0);
      @(negedge clk);
      check("midreset bytes", {res_mem[RES], res_mem[RES+1], res_mem[RES+2], res_mem[RES+3]}, 32'hA5A5_A5A5);
      check("midreset writes", 32'(wr_seen), 32'd0);
      bus.start = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < N; i++) vals[i] = int'($urandom_range(0, 65535)) - 32768;
      do_run("after_reset", 0);

      // Back-to-back random runs, including narrow ranges that force ties.
      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < N; i++)
            vals[i] = (r < 3) ? int'($urandom_range(0, 65535)) - 32768
                              : int'($urandom_range(0, 6)) - 3;
         do_run($sformatf("rand%0d", r), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
